// File: rtl/dff_bank_arbiter.sv
// Round-robin write controller for a shared WIDTH-bit flip-flop bank.
// A grant loads the winner's data, then locks the bank for HOLD_CYC cycles.
module dff_bank_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int OWN_W    = 2,
  parameter int HOLD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] d_flat,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [OWN_W-1:0]      owner,
  output logic                  valid,
  output logic                  busy
);

  localparam int CNT_W = 4;
  localparam int PAD_N = 2**OWN_W;
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;
  localparam logic [OWN_W-1:0] LAST_IDX  = OWN_W'(NREQ - 1);
  localparam bit HAS_HOLD = (HOLD_CYC > 0);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic             valid_q, valid_d;
  logic [NREQ-1:0]  ack_q, ack_d;

  logic [PAD_N-1:0] reqPad;
  logic [OWN_W:0]   cand;
  logic             winFound;
  logic [OWN_W-1:0] winIdx;
  logic [WIDTH-1:0] winData;
  logic [NREQ-1:0]  winOneHot;
  logic [OWN_W-1:0] nextPtr;

  // Padding lets the rotated index address req with exactly OWN_W bits.
  assign reqPad = PAD_N'(req);

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (OWN_W+1)'(k);
      if (cand >= (OWN_W+1)'(NREQ)) begin
        cand = cand - (OWN_W+1)'(NREQ);
      end
      if (!winFound && reqPad[cand[OWN_W-1:0]]) begin
        winFound = 1'b1;
        winIdx   = cand[OWN_W-1:0];
      end
    end
  end

  always_comb begin
    winData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winIdx == OWN_W'(i)) begin
        winData = d_flat[i*WIDTH +: WIDTH];
      end
    end
  end

  assign winOneHot = NREQ'(1) << winIdx;
  assign nextPtr   = (winIdx == LAST_IDX) ? '0 : winIdx + OWN_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bank_d  = bank_q;
    valid_d = valid_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (winFound) begin
          bank_d  = winData;
          owner_d = winIdx;
          valid_d = 1'b1;
          ack_d   = winOneHot;
          ptr_d   = nextPtr;
          if (HAS_HOLD) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      bank_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign ack   = ack_q;
  assign q     = bank_q;
  assign owner = owner_q;
  assign valid = valid_q;
  assign busy  = (state_q == HOLD);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural round-robin model; a second instance covers HOLD_CYC=0.
module tb_dff_bank_arbiter;

  localparam int WIDTH    = 8;
  localparam int NREQ     = 4;
  localparam int OWN_W    = 2;
  localparam int HOLD_CYC = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] dFlat;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [OWN_W-1:0]      owner;
  logic                  valid;
  logic                  busy;

  logic [2:0]  req3;
  logic [23:0] dFlat3;
  logic [2:0]  ack3;
  logic [7:0]  q3;
  logic [1:0]  owner3;
  logic        valid3;
  logic        busy3;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  int              mPtr;
  int              mHold;
  int              mOwner;
  logic [WIDTH-1:0] mQ;
  logic            mValid;
  logic [NREQ-1:0] mAck;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .OWN_W(OWN_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d_flat(dFlat),
    .ack(ack), .q(q), .owner(owner), .valid(valid), .busy(busy)
  );

  dff_bank_arbiter #(.WIDTH(8), .NREQ(3), .OWN_W(2), .HOLD_CYC(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .d_flat(dFlat3),
    .ack(ack3), .q(q3), .owner(owner3), .valid(valid3), .busy(busy3)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPtr   = 0;
    mHold  = 0;
    mOwner = 0;
    mQ     = '0;
    mValid = 1'b0;
    mAck   = '0;
  endtask

  // Spec-level view: a grant is the first requester at or after the pointer,
  // after which the next HOLD_CYC edges are dead time.
  task automatic modelEdge();
    int w;
    w    = -1;
    mAck = '0;
    if (mHold > 0) begin
      mHold--;
    end else if (req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mPtr + k) % NREQ;
        if (w < 0 && req[idx]) w = idx;
      end
      mQ     = dFlat[w*WIDTH +: WIDTH];
      mOwner = w;
      mValid = 1'b1;
      mAck   = NREQ'(1 << w);
      mPtr   = (w + 1) % NREQ;
      mHold  = HOLD_CYC;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".ack"},   32'(ack),   32'(mAck));
    checkValue({tag, ".q"},     32'(q),     32'(mQ));
    checkValue({tag, ".owner"}, 32'(owner), 32'(mOwner));
    checkValue({tag, ".valid"}, 32'(valid), 32'(mValid));
    checkValue({tag, ".busy"},  32'(busy),  32'(mHold > 0));
  endtask

  task automatic applyStimulus(input logic rstVal, input logic [NREQ-1:0] reqVal,
                               input logic [31:0] dVal, input logic [2:0] req3Val,
                               input string tag);
    rst_n = rstVal;
    req   = reqVal;
    dFlat = dVal;
    req3  = req3Val;
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] reqBits;
    int grants;
    int lastCyc;

    rst_n  = 1'b1;
    req    = '0;
    req3   = '0;
    dFlat  = '0;
    dFlat3 = 24'h222120;
    modelReset();
    #1 rst_n = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 32'h0, 3'b000, "reset");
    checkValue("reset q3", 32'(q3), 32'h0);
    checkValue("reset valid3", 32'(valid3), 32'h0);
    checkValue("reset ack3", 32'(ack3), 32'h0);

    applyStimulus(1'b1, 4'b0000, 32'h0, 3'b000, "idle");
    applyStimulus(1'b1, 4'b0100, 32'h00A50000, 3'b000, "single");
    checkValue("single q", 32'(q), 32'hA5);
    checkValue("single owner", 32'(owner), 32'd2);
    checkValue("single ack", 32'(ack), 32'b0100);
    checkValue("single busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'b0000, 32'h00A50000, 3'b000, "single_h1");
    checkValue("single_h1 busy", 32'(busy), 32'd1);
    checkValue("single_h1 ack", 32'(ack), 32'd0);
    applyStimulus(1'b1, 4'b0000, 32'h00A50000, 3'b000, "single_h2");
    checkValue("single_h2 busy", 32'(busy), 32'd0);

    applyStimulus(1'b0, 4'b0000, 32'h0, 3'b000, "rst_contend");
    reqBits = 4'b1111;
    grants  = 0;
    lastCyc = 0;
    for (int c = 0; c < 20 && grants < 5; c++) begin
      applyStimulus(1'b1, reqBits, 32'h13121110, 3'b000, "contend");
      reqBits = 4'b1111 & ~ack;
      if (ack != '0) begin
        checkValue("contend owner", 32'(owner), 32'(grants % 4));
        checkValue("contend q", 32'(q), 32'(8'h10 + grants % 4));
        if (grants > 0) checkValue("contend spacing", 32'(c - lastCyc), 32'd3);
        lastCyc = c;
        grants++;
      end
    end
    checkValue("contend grants", 32'(grants), 32'd5);

    applyStimulus(1'b0, 4'b0000, 32'h0, 3'b000, "rst_rr");
    applyStimulus(1'b1, 4'b0010, 32'h00003344, 3'b000, "rr_g1");
    checkValue("rr_g1 owner", 32'(owner), 32'd1);
    applyStimulus(1'b1, 4'b0000, 32'h00003344, 3'b000, "rr_hold");
    applyStimulus(1'b1, 4'b0000, 32'h00003344, 3'b000, "rr_hold");
    applyStimulus(1'b1, 4'b0011, 32'h00003344, 3'b000, "rr_g0");
    checkValue("rr_g0 owner", 32'(owner), 32'd0);
    checkValue("rr_g0 q", 32'(q), 32'h44);

    applyStimulus(1'b1, 4'b1000, 32'h0000335A, 3'b000, "lock1");
    checkValue("lock1 q", 32'(q), 32'h44);
    checkValue("lock1 ack", 32'(ack), 32'd0);
    applyStimulus(1'b1, 4'b0000, 32'h0000335A, 3'b000, "lock2");
    checkValue("lock2 q", 32'(q), 32'h44);
    applyStimulus(1'b1, 4'b0000, 32'h0000335A, 3'b000, "lock3");
    checkValue("lock3 ack", 32'(ack), 32'd0);
    checkValue("lock3 owner", 32'(owner), 32'd0);

    applyStimulus(1'b1, 4'b0100, 32'h00770000, 3'b000, "pre_rst");
    checkValue("pre_rst busy", 32'(busy), 32'd1);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    checkValue("async q", 32'(q), 32'h0);
    checkValue("async owner", 32'(owner), 32'h0);
    checkValue("async valid", 32'(valid), 32'h0);
    checkValue("async busy", 32'(busy), 32'h0);
    modelReset();
    applyStimulus(1'b0, 4'b0000, 32'h0, 3'b000, "rst_hold");
    applyStimulus(1'b1, 4'b1000, 32'hBB000000, 3'b000, "post_rst");
    checkValue("post_rst owner", 32'(owner), 32'd3);
    checkValue("post_rst q", 32'(q), 32'hBB);
    applyStimulus(1'b1, 4'b0000, 32'hBB000000, 3'b000, "post_hold");
    applyStimulus(1'b1, 4'b0000, 32'hBB000000, 3'b000, "post_hold");
    applyStimulus(1'b1, 4'b1111, 32'h13121110, 3'b000, "post_ptr");
    checkValue("post_ptr owner", 32'(owner), 32'd0);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [NREQ-1:0] rq;
      r  = int'($urandom_range(0, 99));
      rq = (r < 20) ? 4'b0000 : NREQ'($urandom);
      applyStimulus((r < 97), rq, $urandom, 3'b000, "rand");
    end

    applyStimulus(1'b0, 4'b0000, 32'h0, 3'b000, "rst_h0");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'b0000, 32'h0, 3'b111, "h0");
      checkValue("h0 owner", 32'(owner3), 32'(i % 3));
      checkValue("h0 ack", 32'(ack3), 32'(1 << (i % 3)));
      checkValue("h0 q", 32'(q3), 32'(8'h20 + i % 3));
      checkValue("h0 busy", 32'(busy3), 32'd0);
      checkValue("h0 valid", 32'(valid3), 32'd1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit bank of D flip-flops (a shared holding register) between NREQ requesters.
- The winning requester's data is loaded into the bank, then held stable for HOLD_CYC cycles before another load is allowed.
- It sits in front of the latch/flip-flop datapath blocks as their write controller.
- It also reports which requester currently owns the stored value.

Parameters:
- WIDTH, 8, data width of the shared register bank.
- NREQ, 4, number of requesters (2..8).
- OWN_W, 2, width of the owner index; 2**OWN_W >= NREQ is required.
- HOLD_CYC, 2, cycles the bank stays locked after a load (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester load request, level-sensitive.
- d_flat  input  NREQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- ack  output  NREQ  one-hot, one-cycle pulse confirming the load for the granted requester.
- q  output  WIDTH  shared register bank contents.
- owner  output  OWN_W  index of the requester whose data is in q.
- valid  output  1  high once q has been loaded at least once since reset.
- busy  output  1  high while the bank is locked (state HOLD).

Behaviour:
- Reset:
  - Single clock domain (clk). Reset is asynchronous and active-low (rst_n).
  - rst_n low forces, immediately and independent of clk: q=0, owner=0, ack=0, valid=0, busy=0, rr pointer=0, hold counter=0, state=IDLE.
  - Reset mid-HOLD abandons the hold. After release, the first grant again starts its search at requester 0.
- States: IDLE, HOLD. busy is decoded directly from the state register (busy = state==HOLD) and is glitch-free.
- IDLE, req==0 at a rising edge: nothing changes, and ack is driven to 0.
- IDLE, req!=0 at a rising edge (the grant edge):
  - Winner w = first i with req[i]=1, searching from ptr upward and wrapping modulo NREQ.
  - At that same edge: q <= d_flat[w], owner <= w, valid <= 1, ack <= one-hot(w), ptr <= (w+1) mod NREQ.
  - If HOLD_CYC>0: state <= HOLD and cnt <= HOLD_CYC-1. If HOLD_CYC==0: stay IDLE, so a grant is possible every cycle.
  - Latency: req sampled at edge k gives q, owner and ack all valid after edge k. ack is high for exactly the cycle between edges k and k+1.
- HOLD, at each rising edge:
  - ack <= 0.
  - If cnt==0, state <= IDLE; otherwise cnt <= cnt-1.
  - HOLD therefore lasts exactly HOLD_CYC cycles. Grants are spaced HOLD_CYC+1 cycles apart.
- While in HOLD:
  - q and owner are frozen.
  - req is ignored; requests stay pending as long as they are held high.
  - d_flat changes have no effect on q.
- Requester rules:
  - A requester holds req and its data stable until it sees ack.
  - It must drop req in the cycle ack is high. If req is still high afterwards, that counts as a new request and is arbitrated behind the others under round-robin.
  - Dropping req before a grant withdraws the request cleanly.
- Fairness:
  - With all NREQ requesters continuously asserting, grants follow the order 0,1,...,NREQ-1,0,...
  - No requester waits more than NREQ grant slots.
- Simultaneous events:
  - A new req arriving on the same edge the arbiter returns from HOLD to IDLE is not granted on that edge. It is evaluated on the next edge (IDLE is required for a grant).
  - Only one requester is granted per grant edge.
- Width rules:
  - owner carries the winner index zero-extended to OWN_W.
  - ptr wraps from NREQ-1 to 0, including non-power-of-two NREQ (e.g. NREQ=3 wraps 2->0, never 3).
- q retains its last loaded value indefinitely; there is no clear except reset.

Test Plan (WIDTH=8, NREQ=4, HOLD_CYC=2 unless stated):
- Reset then single request: rst_n low 3 cycles, release, req=4'b0100 with data2=8'hA5.
  - After the next edge: q=8'hA5, owner=2, ack=4'b0100 for 1 cycle, valid=1, busy=1 for 2 cycles, then busy=0.
- Full contention: req=4'b1111 held, data i = 8'h10+i, each requester re-asserting after its ack.
  - Grant order 0,1,2,3,0, spaced 3 cycles apart. q sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- Round-robin pointer: grant requester 1, then assert req=4'b0011.
  - The next grant goes to 0 only if 2 and 3 are idle. Check that ptr=2 gives the search order 2,3,0 → owner=0.
- Hold lockout: during HOLD, change data0 and pulse req[3] for 1 cycle only.
  - q stays unchanged and no ack is issued. req[3] is not granted because it was withdrawn before IDLE.
- Async reset mid-HOLD: assert rst_n low between clock edges while busy=1.
  - q=0, owner=0, valid=0, busy=0 immediately, without a clock edge. After release, req=4'b1000 gives owner=3 and ptr=0.
- HOLD_CYC=0, NREQ=3: req=3'b111 held.
  - A grant on every edge in order 0,1,2,0. busy stays 0 throughout. ptr never reaches 3.
